decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/inst_decode.sv | 97 +++++++++
 rtl/decode_ctrl.sv | 132 +++++++++++++
 tb/tb_decode_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode definitions: opcode and immediate-select encodings, the
// ID/EX control bundle and the decode-stage FSM states.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] IMM_R = 3'd1;
  localparam logic [2:0] IMM_I = 3'd2;
  localparam logic [2:0] IMM_S = 3'd3;
  localparam logic [2:0] IMM_B = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;
  localparam logic [2:0] IMM_U = 3'd6;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_REG = 2'b10;
  localparam logic [1:0] ALU_IMM = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [2:0] imm_sel;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MD_BUSY = 2'd2
  } state_e;

endpackage

// File: rtl/inst_decode.sv
// Purely combinational opcode decoder: control bundle, legality and which
// source registers the instruction actually reads.
module inst_decode
  import ctrl_pkg::*;
#(
  parameter bit MD_EN = 1'b1
) (
  input  logic [31:0] inst_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o,
  output logic        rs1_used_o,
  output logic        rs2_used_o,
  output logic        is_md_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = inst_i[6:0];
  assign funct7        = inst_i[31:25];
  assign unused_fields = ^inst_i[24:7];

  // NOTE: every output gets a default before the case, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    ctrl_o     = '0;
    illegal_o  = 1'b0;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    is_md_o    = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_MULDIV && !MD_EN) begin
          illegal_o = 1'b1;
        end else begin
          ctrl_o.alu_op    = ALU_REG;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.imm_sel   = IMM_R;
          rs1_used_o       = 1'b1;
          rs2_used_o       = 1'b1;
          is_md_o          = (funct7 == F7_MULDIV);
        end
      end
      OP_IMM: begin
        ctrl_o.alu_op    = ALU_IMM;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm_sel   = IMM_I;
        rs1_used_o       = 1'b1;
      end
      OP_LOAD: begin
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.imm_sel    = IMM_I;
        rs1_used_o        = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.imm_sel   = IMM_S;
        rs1_used_o       = 1'b1;
        rs2_used_o       = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_o.alu_op  = ALU_BR;
        ctrl_o.branch  = 1'b1;
        ctrl_o.imm_sel = IMM_B;
        rs1_used_o     = 1'b1;
        rs2_used_o     = 1'b1;
      end
      OP_JAL: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm_sel   = IMM_J;
      end
      OP_JALR: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm_sel   = IMM_I;
        rs1_used_o       = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.imm_sel   = IMM_U;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage control: load-use stall, branch flush, multicycle M-op
// sequencing and the registered ID/EX control bundle.
module decode_ctrl
  import ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = 1,
  parameter bit MD_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        br_taken,
  input  logic        md_done,
  output logic        id_ready,
  output logic        pc_stall,
  output logic        if_flush,
  output logic        ctrl_valid,
  output ctrl_t       ctrl,
  output logic        md_start,
  output logic        illegal
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_DEPTH - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       valid_q, valid_d;
  logic       ill_q, ill_d;

  ctrl_t      dec_ctrl;
  logic       dec_illegal;
  logic       dec_rs1_used;
  logic       dec_rs2_used;
  logic       dec_is_md;
  logic       load_use;

  inst_decode #(.MD_EN(MD_EN)) u_dec (
    .inst_i     (id_inst),
    .ctrl_o     (dec_ctrl),
    .illegal_o  (dec_illegal),
    .rs1_used_o (dec_rs1_used),
    .rs2_used_o (dec_rs2_used),
    .is_md_o    (dec_is_md)
  );

  // x0 is never a real dependency, so a load targeting it cannot stall.
  assign load_use = id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((dec_rs1_used && (ex_rd == id_inst[19:15])) ||
                     (dec_rs2_used && (ex_rd == id_inst[24:20])));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_d   = '0;
    valid_d  = 1'b0;
    ill_d    = 1'b0;
    id_ready = 1'b1;
    pc_stall = 1'b0;
    if_flush = 1'b0;
    md_start = 1'b0;
    case (state_q)
      RUN: begin
        if (br_taken) begin
          if_flush = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end else if (load_use) begin
          pc_stall = 1'b1;
          id_ready = 1'b0;
        end else if (id_valid) begin
          if (dec_illegal) begin
            ill_d = 1'b1;
          end else begin
            ctrl_d  = dec_ctrl;
            valid_d = 1'b1;
            if (dec_is_md) begin
              md_start = 1'b1;
              state_d  = MD_BUSY;
            end
          end
        end
      end
      FLUSH: begin
        if_flush = 1'b1;
        cnt_d    = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = RUN;
      end
      MD_BUSY: begin
        pc_stall = 1'b1;
        id_ready = 1'b0;
        if (md_done) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // Reset must not leak a stall, flush or M-unit launch into the pipeline.
    if (rst) begin
      id_ready = 1'b1;
      pc_stall = 1'b0;
      if_flush = 1'b0;
      md_start = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every register samples the values
  // that existed before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  assign ctrl       = ctrl_q;
  assign ctrl_valid = valid_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: a FLUSH_DEPTH=3/MD_EN=1 instance checked through a
// vector table, hand sequences and a scoreboard, plus a FLUSH_DEPTH=1/MD_EN=0 instance.
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        br_taken;
  logic        md_done;

  logic        id_ready, pc_stall, if_flush, ctrl_valid, md_start, illegal;
  logic [11:0] ctrl_w;
  logic        id_ready_nm, pc_stall_nm, if_flush_nm, ctrl_valid_nm, md_start_nm, illegal_nm;
  logic [11:0] ctrl_nm;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_ctrl #(.FLUSH_DEPTH(3), .MD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken), .md_done(md_done),
    .id_ready(id_ready), .pc_stall(pc_stall), .if_flush(if_flush),
    .ctrl_valid(ctrl_valid), .ctrl(ctrl_w), .md_start(md_start), .illegal(illegal)
  );

  decode_ctrl #(.FLUSH_DEPTH(1), .MD_EN(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken), .md_done(md_done),
    .id_ready(id_ready_nm), .pc_stall(pc_stall_nm), .if_flush(if_flush_nm),
    .ctrl_valid(ctrl_valid_nm), .ctrl(ctrl_nm), .md_start(md_start_nm), .illegal(illegal_nm)
  );

  function automatic logic [11:0] mkc(input logic [1:0] op, input logic src, input logic br,
                                      input logic j, input logic mr, input logic mw,
                                      input logic rw, input logic m2r, input logic [2:0] imm);
    return {op, src, br, j, mr, mw, rw, m2r, imm};
  endfunction

  localparam logic [11:0] C_R    = {2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1};
  logic [11:0] c_i, c_ld, c_st, c_br, c_jal, c_jalr, c_u;

  localparam logic [31:0] I_ADD   = {7'b0000000, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] I_MUL   = {7'b0000001, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
  localparam logic [31:0] I_ADDI  = {12'd1, 5'd5, 3'd0, 5'd4, 7'b0010011};
  localparam logic [31:0] I_ADDI2 = {12'd5, 5'd2, 3'd0, 5'd4, 7'b0010011};
  localparam logic [31:0] I_LW    = {12'd0, 5'd5, 3'b000, 5'd7, 7'b0000011};
  localparam logic [31:0] I_SW    = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'b0100011};
  localparam logic [31:0] I_BEQ   = {7'd0, 5'd5, 5'd1, 3'b000, 5'd0, 7'b1100011};
  localparam logic [31:0] I_JAL   = {12'h000, 5'd5, 3'd0, 5'd1, 7'b1101111};
  localparam logic [31:0] I_JALR  = {12'd0, 5'd5, 3'd0, 5'd1, 7'b1100111};
  localparam logic [31:0] I_LUI   = {12'h123, 5'd5, 3'd0, 5'd3, 7'b0110111};
  localparam logic [31:0] I_AUIPC = {12'h000, 5'd5, 3'd0, 5'd3, 7'b0010111};
  localparam logic [31:0] I_BAD   = {25'd0, 7'b1111111};

  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic        mr;
    logic [4:0]  rd;
    logic        stall;
    logic [11:0] ctrl;
    logic        valid;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [11:0] ctrl;
    logic        valid;
    logic        ill;
  } sb_t;

  vec_t  tbl[$];
  sb_t   sb[$];
  string sb_tag[$];
  sb_t   mon_e;
  string mon_t;

  function automatic vec_t mkv(input logic v, input logic [31:0] inst, input logic mr,
                               input logic [4:0] rd, input logic stall, input logic [11:0] c,
                               input logic valid, input logic ill);
    vec_t r;
    r.v = v; r.inst = inst; r.mr = mr; r.rd = rd;
    r.stall = stall; r.ctrl = c; r.valid = valid; r.ill = ill;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Registered outputs appear one edge after the cycle that pushed them.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_t = sb_tag.pop_front();
      check($sformatf("%s ctrl", mon_t), 32'(ctrl_w), 32'(mon_e.ctrl));
      check($sformatf("%s ctrl_valid", mon_t), 32'(ctrl_valid), 32'(mon_e.valid));
      check($sformatf("%s illegal", mon_t), 32'(illegal), 32'(mon_e.ill));
    end
  end

  task automatic step(input logic v, input logic [31:0] inst, input logic mr, input logic [4:0] rd,
                      input logic bt, input logic md,
                      input logic e_flush, input logic e_stall, input logic e_ready, input logic e_start,
                      input logic [11:0] e_ctrl, input logic e_valid, input logic e_ill,
                      input string tag);
    sb_t e;
    id_valid = v; id_inst = inst; ex_mem_read = mr; ex_rd = rd; br_taken = bt; md_done = md;
    #1;
    check($sformatf("%s if_flush", tag), 32'(if_flush), 32'(e_flush));
    check($sformatf("%s pc_stall", tag), 32'(pc_stall), 32'(e_stall));
    check($sformatf("%s id_ready", tag), 32'(id_ready), 32'(e_ready));
    check($sformatf("%s md_start", tag), 32'(md_start), 32'(e_start));
    check($sformatf("%s nm if_flush", tag), 32'(if_flush_nm), 32'(bt & ~rst));
    e.ctrl = e_ctrl; e.valid = e_valid; e.ill = e_ill;
    sb.push_back(e);
    sb_tag.push_back(tag);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    c_i    = mkc(2'b11, 1, 0, 0, 0, 0, 1, 0, 3'd2);
    c_ld   = mkc(2'b00, 1, 0, 0, 1, 0, 1, 1, 3'd2);
    c_st   = mkc(2'b00, 1, 0, 0, 0, 1, 0, 0, 3'd3);
    c_br   = mkc(2'b01, 0, 1, 0, 0, 0, 0, 0, 3'd4);
    c_jal  = mkc(2'b00, 0, 0, 1, 0, 0, 1, 0, 3'd5);
    c_jalr = mkc(2'b00, 1, 0, 1, 0, 0, 1, 0, 3'd2);
    c_u    = mkc(2'b00, 1, 0, 0, 0, 0, 1, 0, 3'd6);

    tbl.push_back(mkv(1, I_ADD,   0, 5'd0, 0, C_R,    1, 0));
    tbl.push_back(mkv(1, I_ADDI,  0, 5'd0, 0, c_i,    1, 0));
    tbl.push_back(mkv(1, I_LW,    0, 5'd0, 0, c_ld,   1, 0));
    tbl.push_back(mkv(1, I_SW,    0, 5'd0, 0, c_st,   1, 0));
    tbl.push_back(mkv(1, I_BEQ,   0, 5'd0, 0, c_br,   1, 0));
    tbl.push_back(mkv(1, I_JAL,   0, 5'd0, 0, c_jal,  1, 0));
    tbl.push_back(mkv(1, I_JALR,  0, 5'd0, 0, c_jalr, 1, 0));
    tbl.push_back(mkv(1, I_LUI,   0, 5'd0, 0, c_u,    1, 0));
    tbl.push_back(mkv(1, I_AUIPC, 0, 5'd0, 0, c_u,    1, 0));
    tbl.push_back(mkv(1, I_BAD,   0, 5'd0, 0, 12'd0,  0, 1));
    tbl.push_back(mkv(1, I_ADD,   1, 5'd5, 1, 12'd0,  0, 0));
    tbl.push_back(mkv(1, I_ADD,   0, 5'd5, 0, C_R,    1, 0));
    tbl.push_back(mkv(1, I_ADD,   1, 5'd0, 0, C_R,    1, 0));
    tbl.push_back(mkv(1, I_ADD,   1, 5'd6, 0, C_R,    1, 0));
    tbl.push_back(mkv(1, I_SW,    1, 5'd5, 1, 12'd0,  0, 0));
    tbl.push_back(mkv(1, I_BEQ,   1, 5'd5, 1, 12'd0,  0, 0));
    tbl.push_back(mkv(1, I_ADDI,  1, 5'd5, 1, 12'd0,  0, 0));
    tbl.push_back(mkv(1, I_JALR,  1, 5'd5, 1, 12'd0,  0, 0));
    tbl.push_back(mkv(1, I_JAL,   1, 5'd5, 0, c_jal,  1, 0));
    tbl.push_back(mkv(1, I_LUI,   1, 5'd5, 0, c_u,    1, 0));
    tbl.push_back(mkv(1, I_AUIPC, 1, 5'd5, 0, c_u,    1, 0));
    tbl.push_back(mkv(0, I_ADD,   1, 5'd5, 0, 12'd0,  0, 0));
    tbl.push_back(mkv(1, I_ADD,   1, 5'd1, 1, 12'd0,  0, 0));
    tbl.push_back(mkv(1, I_ADDI2, 1, 5'd5, 0, c_i,    1, 0));

    // Reset: combinational outputs forced quiet even with a branch, an M-op or a hazard.
    rst = 1'b1;
    step(1, I_MUL, 0, 5'd0, 1, 0, 0, 0, 1, 0, 12'd0, 0, 0, "reset0");
    step(1, I_ADD, 1, 5'd5, 0, 0, 0, 0, 1, 0, 12'd0, 0, 0, "reset1");
    rst = 1'b0;

    foreach (tbl[i])
      step(tbl[i].v, tbl[i].inst, tbl[i].mr, tbl[i].rd, 0, 0,
           0, tbl[i].stall, ~tbl[i].stall, 0, tbl[i].ctrl, tbl[i].valid, tbl[i].ill,
           $sformatf("vec%0d", i));

    // Branch flush with depth 3; the second br_taken lands in FLUSH and is ignored.
    step(1, I_ADD, 0, 5'd0, 1, 0, 1, 0, 1, 0, 12'd0, 0, 0, "flush0");
    step(1, I_ADD, 0, 5'd0, 1, 0, 1, 0, 1, 0, 12'd0, 0, 0, "flush1");
    step(1, I_ADD, 0, 5'd0, 0, 0, 1, 0, 1, 0, 12'd0, 0, 0, "flush2");
    step(1, I_ADD, 0, 5'd0, 0, 0, 0, 0, 1, 0, C_R,   1, 0, "flush3");

    // M-op: md_done coincident with md_start is ignored, real md_done 4 cycles later.
    step(1, I_MUL, 0, 5'd0, 0, 1, 0, 0, 1, 1, C_R,   1, 0, "md1");
    check("nm mul illegal", 32'(illegal_nm), 32'd1);
    check("nm mul ctrl_valid", 32'(ctrl_valid_nm), 32'd0);
    check("nm mul ctrl", 32'(ctrl_nm), 32'd0);
    step(1, I_ADD, 0, 5'd0, 0, 0, 0, 1, 0, 0, 12'd0, 0, 0, "md2");
    check("nm illegal pulse end", 32'(illegal_nm), 32'd0);
    step(1, I_ADD, 0, 5'd0, 0, 0, 0, 1, 0, 0, 12'd0, 0, 0, "md3");
    step(1, I_ADD, 0, 5'd0, 0, 0, 0, 1, 0, 0, 12'd0, 0, 0, "md4");
    step(1, I_ADD, 0, 5'd0, 0, 1, 0, 1, 0, 0, 12'd0, 0, 0, "md5");
    step(1, I_ADD, 0, 5'd0, 0, 0, 0, 0, 1, 0, C_R,   1, 0, "md6");

    // Reset during MD_BUSY abandons the op; a later md_done does nothing.
    step(1, I_MUL, 0, 5'd0, 0, 0, 0, 0, 1, 1, C_R,   1, 0, "mdrst0");
    step(1, I_ADD, 0, 5'd0, 0, 0, 0, 1, 0, 0, 12'd0, 0, 0, "mdrst1");
    rst = 1'b1;
    step(1, I_ADD, 0, 5'd0, 0, 0, 0, 0, 1, 0, 12'd0, 0, 0, "mdrst2");
    rst = 1'b0;
    step(0, I_ADD, 0, 5'd0, 0, 1, 0, 0, 1, 0, 12'd0, 0, 0, "mdrst3");
    step(1, I_ADD, 0, 5'd0, 0, 0, 0, 0, 1, 0, C_R,   1, 0, "mdrst4");

    // Reset during FLUSH drops the remaining flush cycles.
    step(1, I_ADD, 0, 5'd0, 1, 0, 1, 0, 1, 0, 12'd0, 0, 0, "flrst0");
    rst = 1'b1;
    step(1, I_ADD, 0, 5'd0, 0, 0, 0, 0, 1, 0, 12'd0, 0, 0, "flrst1");
    rst = 1'b0;
    step(1, I_ADD, 0, 5'd0, 0, 0, 0, 0, 1, 0, C_R,   1, 0, "flrst2");

    id_valid = 1'b0;
    br_taken = 1'b0;
    md_done  = 1'b0;
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
